// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MIPS mult/multu/div/divu sequencer that owns the HI/LO pair.
// Define MULDIV_ABORT_EN to add an abort input that cancels an in-flight operation.
module muldiv_unit #(
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata,
`ifdef MULDIV_ABORT_EN
    input  logic        abort,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_SIGN, S_DONE} state_t;

    localparam logic [4:0] CNT_MUL = 5'(MUL_LATENCY - 1);

    state_t      state, state_nx;
    logic        kill;
    logic        accept;
    logic [4:0]  cnt;
    logic        mul_unsigned;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] rem;
    logic        sign_q, sign_r, dz_r;
    logic [31:0] abs_a, abs_b;
    logic [63:0] prod_u;
    logic signed [63:0] prod_s;
    logic [32:0] shifted, diff;
    logic        take;

`ifdef MULDIV_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    assign abs_a = (op == 2'b10 && src_a[31]) ? -src_a : src_a;
    assign abs_b = (op == 2'b10 && src_b[31]) ? -src_b : src_b;

    assign prod_u = {32'b0, a_r} * {32'b0, b_r};
    assign prod_s = $signed({{32{a_r[31]}}, a_r}) * $signed({{32{b_r[31]}}, b_r});

    // During DIV, a_r shifts the dividend out of its MSB while quotient bits enter at the LSB.
    assign shifted = {rem, a_r[31]};
    assign diff    = shifted - {1'b0, b_r};
    assign take    = !diff[32];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        div_zero = 1'b0;
        accept   = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                done     = (state == S_DONE);
                div_zero = (state == S_DONE) && dz_r;
                if (start) begin
                    accept = 1'b1;
                    if (!op[1])
                        state_nx = S_MUL;
                    else if (src_b == '0)
                        state_nx = S_DONE;
                    else
                        state_nx = S_DIV;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (kill)
                    state_nx = S_IDLE;
                else if (cnt == '0)
                    state_nx = S_DONE;
            end
            S_DIV: begin
                busy = 1'b1;
                if (kill)
                    state_nx = S_IDLE;
                else if (cnt == '0)
                    state_nx = S_SIGN;
            end
            S_SIGN: begin
                busy     = 1'b1;
                state_nx = kill ? S_IDLE : S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            hi           <= '0;
            lo           <= '0;
            cnt          <= '0;
            mul_unsigned <= 1'b0;
            a_r          <= '0;
            b_r          <= '0;
            rem          <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            dz_r         <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        mul_unsigned <= op[0];
                        dz_r         <= op[1] && (src_b == '0);
                        rem          <= '0;
                        if (op[1]) begin
                            a_r    <= abs_a;
                            b_r    <= abs_b;
                            cnt    <= 5'd31;
                            sign_q <= !op[0] && (src_a[31] ^ src_b[31]);
                            sign_r <= !op[0] && src_a[31];
                        end else begin
                            a_r    <= src_a;
                            b_r    <= src_b;
                            cnt    <= CNT_MUL;
                            sign_q <= 1'b0;
                            sign_r <= 1'b0;
                        end
                    end else begin
                        if (we_hi)
                            hi <= wdata;
                        if (we_lo)
                            lo <= wdata;
                    end
                end
                S_MUL: begin
                    if (!kill) begin
                        cnt <= cnt - 5'd1;
                        if (cnt == '0)
                            {hi, lo} <= mul_unsigned ? prod_u : prod_s;
                    end
                end
                S_DIV: begin
                    if (!kill) begin
                        cnt <= cnt - 5'd1;
                        rem <= take ? diff[31:0] : shifted[31:0];
                        a_r <= {a_r[30:0], take};
                    end
                end
                S_SIGN: begin
                    if (!kill) begin
                        lo <= sign_q ? -a_r : a_r;
                        hi <= sign_r ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model compared every cycle,
// plus directed vectors with literal expected HI/LO values and latencies.
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam int unsigned LAT = 4;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        we_hi = 1'b0;
    logic        we_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;
    logic        ab_now;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_ABORT_EN
    logic abort = 1'b0;
    assign ab_now = abort;
`else
    assign ab_now = 1'b0;
`endif

    muldiv_unit #(.MUL_LATENCY(LAT)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .we_hi    (we_hi),
        .we_lo    (we_lo),
        .wdata    (wdata),
`ifdef MULDIV_ABORT_EN
        .abort    (abort),
`endif
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result of an operation from plain integer arithmetic: {hi, lo}.
    function automatic logic [63:0] expect64(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, q, r;
        case (o)
            2'b00: return 64'(longint'(int'(a)) * longint'(int'(b)));
            2'b01: return 64'(a) * 64'(b);
            2'b10: begin
                sa = longint'(int'(a));
                sb = longint'(int'(b));
                q  = sa / sb;
                r  = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: return {a % b, a / b};
        endcase
    endfunction

    // Timeline model: m_left counts remaining busy cycles; results land when it expires.
    logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
    int          m_left = 0;
    logic        m_done = 1'b0, m_dz = 1'b0;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_left > 0) begin
                if (ab_now) begin
                    m_left <= 0;
                end else if (m_left == 1) begin
                    m_left <= 0;
                    m_hi   <= r_hi;
                    m_lo   <= r_lo;
                    m_done <= 1'b1;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (start) begin
                if (op[1] && src_b == '0) begin
                    m_done <= 1'b1;
                    m_dz   <= 1'b1;
                end else begin
                    m_left       <= op[1] ? 33 : int'(LAT);
                    {r_hi, r_lo} <= expect64(op, src_a, src_b);
                end
            end else begin
                if (we_hi) m_hi <= wdata;
                if (we_lo) m_lo <= wdata;
            end
        end
    end

    always @(negedge clock) begin
        chk("cyc_busy", 32'(busy), 32'(m_left > 0));
        chk("cyc_done", 32'(done), 32'(m_done));
        chk("cyc_div_zero", 32'(div_zero), 32'(m_dz));
        chk("cyc_hi", hi, m_hi);
        chk("cyc_lo", lo, m_lo);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] d);
        we_hi = h;
        we_lo = l;
        wdata = d;
        step();
        we_hi = 1'b0;
        we_lo = 1'b0;
    endtask

    // Issues an op in the current cycle and returns in its done cycle; inj>0 pulses
    // a foreign start plus an mthi write during that busy cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc, input int inj);
        int n;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        step();
        start = 1'b0;
        n = 1;
        while (!done && n < 60) begin
            if (n == inj) begin
                start = 1'b1;
                op    = 2'b00;
                src_a = 32'h0000_1234;
                src_b = 32'h0000_5678;
                we_hi = 1'b1;
                wdata = 32'hDEAD_BEEF;
            end
            step();
            start = 1'b0;
            we_hi = 1'b0;
            n++;
        end
        chk("latency", 32'(n), 32'(exp_cyc));
    endtask

    initial begin
        step();
        step();
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        step();

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 5, 0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        step();

        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 5, 0);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        step();

        run_op(2'b11, 32'd100, 32'd7, 34, 0);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        step();

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 34, 0);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        step();

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 0);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0);
        step();

        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        run_op(2'b10, 32'd5, 32'd0, 1, 0);
        chk("dz_flag", 32'(div_zero), 32'h1);
        chk("dz_busy", 32'(busy), 32'h0);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);
        step();

        run_op(2'b11, 32'd1000, 32'd33, 34, 10);
        chk("guard_lo", lo, 32'd30);
        chk("guard_hi", hi, 32'd10);
        run_op(2'b00, 32'd7, 32'hFFFF_FFFA, 5, 0);
        chk("b2b_hi", hi, 32'hFFFF_FFFF);
        chk("b2b_lo", lo, 32'hFFFF_FFD6);
        step();

        start = 1'b1;
        op    = 2'b10;
        src_a = 32'd1000;
        src_b = 32'hFFFF_FFFD;
        step();
        start = 1'b0;
        for (int n = 1; n < 15; n++) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        step();
        rst_n = 1'b1;
        for (int n = 0; n < 25; n++) step();
        run_op(2'b11, 32'd9, 32'd3, 34, 0);
        chk("post_rst_lo", lo, 32'd3);
        chk("post_rst_hi", hi, 32'd0);
        step();

        mt(1'b1, 1'b1, 32'h5A);
`ifdef MULDIV_ABORT_EN
        begin
            int pulses;
            pulses = 0;
            start = 1'b1;
            op    = 2'b00;
            src_a = 32'd3;
            src_b = 32'd4;
            step();
            start = 1'b0;
            step();
            abort = 1'b1;
            step();
            abort = 1'b0;
            for (int n = 0; n < 8; n++) begin
                if (done) pulses++;
                step();
            end
            chk("abort_done_pulses", 32'(pulses), 32'h0);
            chk("abort_busy", 32'(busy), 32'h0);
            chk("abort_hi", hi, 32'h5A);
            chk("abort_lo", lo, 32'h5A);
        end
`else
        run_op(2'b00, 32'd3, 32'd4, 5, 0);
        chk("noabort_hi", hi, 32'h0);
        chk("noabort_lo", lo, 32'd12);
`endif
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide sequencer with its HI/LO register pair.
- Executes MIPS mult, multu, div and divu, and accepts mthi/mtlo writes.
- Drives a busy signal that the instruction decoder uses to stall mfhi, mflo, mthi, mtlo and further mult/div instructions.
- Sits beside the ALU in the execute stage; operands come from the register file read ports.

Parameters:
- MUL_LATENCY, default 4: number of busy cycles for mult/multu; legal range 1..16.

Ports:
- clock       input   1   system clock, rising-edge
- rst_n       input   1   asynchronous, active-low reset
- start       input   1   single-cycle request to begin the operation selected by op
- op          input   2   00 mult, 01 multu, 10 div, 11 divu
- src_a       input   32  rs operand (multiplicand or dividend)
- src_b       input   32  rt operand (multiplier or divisor)
- we_hi       input   1   mthi write enable
- we_lo       input   1   mtlo write enable
- wdata       input   32  mthi/mtlo data
- hi          output  32  HI register
- lo          output  32  LO register
- busy        output  1   operation in progress; decoder stalls on it
- done        output  1   one-cycle pulse: result committed to HI/LO
- div_zero    output  1   one-cycle pulse together with done; the divide had divisor 0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - hi=0, lo=0, busy=0, done=0, div_zero=0.
  - Counter and internal operand registers are cleared.
  - A reset mid-operation discards the operation; no done pulse is produced.
- States:
  - IDLE: waiting for start.
  - MUL: multiply in progress.
  - DIV: iterative divide in progress.
  - SIGN: sign correction of the divide result.
  - DONE: result presentation.
- busy=1 in MUL, DIV and SIGN only.
- done=1 in DONE only.
- start is sampled in IDLE and DONE; a start arriving in MUL, DIV or SIGN is ignored.
- At a sampled start, the unit latches op, src_a and src_b.
- Multiply path (op 00 or 01):
  - Enter MUL with the counter at MUL_LATENCY-1.
  - The counter decrements each cycle.
  - When the counter is 0, {hi,lo} takes the 64-bit product: signed for mult, unsigned for multu. The state then goes to DONE.
  - Timing: busy is high for MUL_LATENCY cycles; done is high in the following cycle.
- Divide path (op 10 or 11, src_b != 0):
  - The unit latches the magnitudes. For div, a negative operand is negated; 0x80000000 has magnitude 0x80000000 as an unsigned value.
  - It records sign_q = a[31]^b[31] and sign_r = a[31]; both are forced to 0 for divu.
  - DIV performs a radix-2 restoring divide with a 33-bit partial remainder, one quotient bit per cycle, for exactly 32 cycles. The counter runs 31 down to 0.
  - SIGN takes one cycle:
    - lo = sign_q ? -quotient : quotient
    - hi = sign_r ? -remainder : remainder
    - The state then goes to DONE.
  - Timing: busy is high for 33 cycles; done is high in the 34th cycle.
  - Overflow case: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. The result wraps; no flag is raised.
- Divide by zero (op 1x, src_b == 0):
  - Go directly from IDLE/DONE to DONE.
  - hi and lo are unchanged.
  - done=1 and div_zero=1 for one cycle; busy is never asserted.
- mthi/mtlo:
  - In IDLE or DONE with no start: we_hi writes hi, and we_lo writes lo, at the clock edge. Both may be written in the same cycle.
  - Ignored in MUL, DIV and SIGN.
  - If a write and start occur in the same cycle, start wins and the write is dropped.
- DONE → IDLE after one cycle, unless start is sampled, in which case the new operation begins immediately (back-to-back).
- hi and lo change only at: reset, an mt write, MUL completion, and the SIGN state. They are stable at all other times.

Optional Feature:
- Macro: MULDIV_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 in MUL, DIV or SIGN returns the unit to IDLE at the next edge.
  - hi and lo are unchanged, and done is not pulsed.
  - abort is ignored in IDLE and DONE.
  - The decoder uses this to cancel the unit on an exception or branch flush.
- When undefined:
  - The port does not exist.
  - Operations always run to completion unless reset.

Test Plan:
- mult, src_a=0xFFFFFFFD (-3), src_b=5 → busy for 4 cycles, then done; hi=0xFFFFFFFF, lo=0xFFFFFFF1. multu 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE.
- divu 100/7 → busy for 33 cycles, done in cycle 34; lo=14, hi=2. div -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/-1 → lo=0x80000000, hi=0.
- div 5/0 with hi=0x11, lo=0x22 preloaded by mthi/mtlo → next cycle done=1 and div_zero=1, busy=0; hi=0x11, lo=0x22 unchanged.
- During a divu, pulse start (mult) and we_hi at cycle 10 → both ignored; divu result correct. Then start in the DONE cycle → new mult runs back-to-back with correct product.
- rst_n low at cycle 15 of a div → hi=lo=0 and busy=0 immediately; no done pulse. A subsequent divu 9/3 gives lo=3, hi=0.
- With MULDIV_ABORT_EN defined: abort in cycle 2 of a mult → IDLE, hi/lo hold their prior values, no done pulse. Without the macro, the same bench (abort unconnected) still runs the mult to completion.
